// File: rtl/csr_file_m_if.sv
// Decode-side read port and writeback-side write port of the machine-mode CSR file.
// The master drives addresses and write data; the CSR file (slave) answers reads.
interface csr_file_m_if;
  logic [11:0] read_address;
  logic [31:0] read_data;
  logic        readable;
  logic        writeable;
  logic        write_enable;
  logic [11:0] write_address;
  logic [31:0] write_data;

  modport master (
    output read_address, write_enable, write_address, write_data,
    input  read_data, readable, writeable
  );

  modport slave (
    input  read_address, write_enable, write_address, write_data,
    output read_data, readable, writeable
  );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: status/trap state, interrupt sampling, cycle/instret/HPM counters.
// Define CSR_VECTORED_MTVEC_EN to enable vectored interrupt dispatch through mtvec[1:0].
module csr_file_m #(
  parameter int          HPM_COUNT     = 4,
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] MTVEC_RESET   = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  csr_file_m_if.slave          bus,
  input  logic                 retired,
  input  logic                 traped,
  input  logic                 trap_interrupt,
  input  logic [3:0]           trap_code,
  input  logic [31:0]          trap_value,
  input  logic                 mret,
  input  logic [31:0]          ecp,
  input  logic [HPM_COUNT-1:0] hpm_event,
  input  logic                 ext_irq,
  input  logic                 timer_irq,
  input  logic                 soft_irq,
  output logic                 eip,
  output logic                 tip,
  output logic                 sip,
  output logic [31:0]          trap_vector,
  output logic [31:0]          mret_vector
);

  localparam int          NCNT         = 3 + HPM_COUNT;
  localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'd1 << HPM_COUNT) - 32'd1) << 3);

  typedef struct packed {
    logic rd;
    logic wr;
  } access_t;

  logic [COUNTER_WIDTH-1:0] cnt [NCNT];
  logic [NCNT-1:0]          inc;
  logic                     ie, pie;
  logic [31:0]              mie_r, inhibit, mscratch, mepc, mcause, mtval;
  logic [29:0]              mtvec_base;
  logic [31:0]              mtvec_rd, mip, rdata;
  logic [4:0]               rsel;
  access_t                  acc_r, acc_w;
  logic                     we_ok, cnt_we;
`ifdef CSR_VECTORED_MTVEC_EN
  logic                     mtvec_mode;
`endif

  // Counter windows: C00-C1F / C80-C9F (user view) and B00-B1F / B80-B9F (machine view).
  function automatic logic is_counter_space(input logic [11:0] a);
    return (a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00;
  endfunction

  function automatic logic cnt_impl(input logic [4:0] idx, input logic user);
    return (idx == 5'd0) || (idx == 5'd2) || (user && idx == 5'd1) ||
           (idx >= 5'd3 && int'(idx) < NCNT);
  endfunction

  function automatic access_t decode(input logic [11:0] a);
    access_t r;
    r = '0;
    if (is_counter_space(a)) begin
      r.rd = 1'b1;
      r.wr = (a[11:8] == 4'hB);
    end else if (a >= 12'hF11 && a <= 12'hF14) begin
      r.rd = 1'b1;
    end else if (a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h320,
                           [12'h323:12'h33F], [12'h340:12'h344]}) begin
      r.rd = 1'b1;
      r.wr = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] get_half(input logic [COUNTER_WIDTH-1:0] cur, input logic hi);
    logic [63:0] w;
    w = 64'(cur);
    return hi ? w[63:32] : w[31:0];
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] put_half(input logic [COUNTER_WIDTH-1:0] cur,
                                                        input logic hi, input logic [31:0] d);
    logic [63:0] w;
    w = 64'(cur);
    if (hi) w[63:32] = d;
    else    w[31:0]  = d;
    return w[COUNTER_WIDTH-1:0];
  endfunction

  assign acc_r  = decode(bus.read_address);
  assign acc_w  = decode(bus.write_address);
  assign we_ok  = bus.write_enable & acc_w.wr;
  assign cnt_we = we_ok && is_counter_space(bus.write_address) &&
                  cnt_impl(bus.write_address[4:0], 1'b0);

  assign mip = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, soft_irq, 3'b0};
`ifdef CSR_VECTORED_MTVEC_EN
  assign mtvec_rd    = {mtvec_base, 1'b0, mtvec_mode};
  assign trap_vector = (mtvec_mode && mcause[31]) ?
                       {mtvec_base, 2'b00} + {26'b0, mcause[3:0], 2'b00} : {mtvec_base, 2'b00};
`else
  assign mtvec_rd    = {mtvec_base, 2'b00};
  assign trap_vector = {mtvec_base, 2'b00};
`endif
  assign mret_vector = mepc;

  assign eip = ie & mie_r[11] & ext_irq;
  assign tip = ie & mie_r[7]  & timer_irq;
  assign sip = ie & mie_r[3]  & soft_irq;

  // C01 is an alias of the cycle counter in the user view.
  assign rsel = (bus.read_address[4:0] == 5'd1) ? 5'd0 : bus.read_address[4:0];

  always_comb begin
    rdata = '0;
    if (is_counter_space(bus.read_address)) begin
      if (cnt_impl(bus.read_address[4:0], bus.read_address[11:8] == 4'hC)) begin
        for (int n = 0; n < NCNT; n++) begin
          if (5'(n) == rsel) rdata = get_half(cnt[n], bus.read_address[7]);
        end
      end
    end else begin
      case (bus.read_address)
        12'h300: rdata = {24'b0, pie, 3'b0, ie, 3'b0};
        12'h301: rdata = 32'h4000_0100;
        12'h304: rdata = mie_r;
        12'h305: rdata = mtvec_rd;
        12'h320: rdata = inhibit;
        12'h340: rdata = mscratch;
        12'h341: rdata = mepc;
        12'h342: rdata = mcause;
        12'h343: rdata = mtval;
        12'h344: rdata = mip;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.read_data = rdata;
  assign bus.readable  = acc_r.rd;
  assign bus.writeable = acc_r.wr;

  always_comb begin
    inc    = '0;
    inc[0] = ~inhibit[0];
    inc[2] = retired & ~inhibit[2];
    for (int i = 0; i < HPM_COUNT; i++) inc[3+i] = hpm_event[i] & ~inhibit[3+i];
  end

  // A CSR write to either half takes precedence over that counter's increment.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NCNT; n++) begin
      if (reset)
        cnt[n] <= '0;
      else if (cnt_we && bus.write_address[4:0] == 5'(n))
        cnt[n] <= put_half(cnt[n], bus.write_address[7], bus.write_data);
      else if (inc[n])
        cnt[n] <= cnt[n] + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie         <= 1'b0;
      pie        <= 1'b0;
      mie_r      <= '0;
      mtvec_base <= MTVEC_RESET[31:2];
`ifdef CSR_VECTORED_MTVEC_EN
      mtvec_mode <= 1'b0;
`endif
      inhibit    <= '0;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
    end else begin
      // A trap overrides mret and any same-cycle write to the trap-state CSRs.
      if (traped) begin
        mepc   <= ecp & ~32'h3;
        mcause <= {trap_interrupt, 27'b0, trap_code};
        mtval  <= trap_value;
        pie    <= ie;
        ie     <= 1'b0;
      end else begin
        if (mret) begin
          ie  <= pie;
          pie <= 1'b1;
        end else if (we_ok && bus.write_address == 12'h300) begin
          ie  <= bus.write_data[3];
          pie <= bus.write_data[7];
        end
        if (we_ok) begin
          case (bus.write_address)
            12'h341: mepc   <= bus.write_data & ~32'h3;
            12'h342: mcause <= bus.write_data & 32'h8000_000F;
            12'h343: mtval  <= bus.write_data;
            default: ;
          endcase
        end
      end
      if (we_ok) begin
        case (bus.write_address)
          12'h304: mie_r <= bus.write_data & 32'h0000_0888;
          12'h305: begin
            mtvec_base <= bus.write_data[31:2];
`ifdef CSR_VECTORED_MTVEC_EN
            mtvec_mode <= (bus.write_data[1:0] == 2'b01);
`endif
          end
          12'h320: inhibit  <= bus.write_data & INHIBIT_MASK;
          12'h340: mscratch <= bus.write_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: directed scenarios plus randomized traffic against a
// register-level behavioural model of the CSR address map.
module tb_csr_file_m;
  localparam int          HPM = 4;
  localparam int          CW  = 64;
  localparam logic [31:0] MTR = 32'h0000_0083;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csr_file_m_if bus();
  logic           retired, traped, trap_interrupt, mret, ext_irq, timer_irq, soft_irq;
  logic [3:0]     trap_code;
  logic [31:0]    trap_value, ecp;
  logic [HPM-1:0] hpm_event;
  logic           eip, tip, sip;
  logic [31:0]    trap_vector, mret_vector;

  csr_file_m #(.HPM_COUNT(HPM), .COUNTER_WIDTH(CW), .MTVEC_RESET(MTR)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .retired(retired), .traped(traped), .trap_interrupt(trap_interrupt),
    .trap_code(trap_code), .trap_value(trap_value), .mret(mret), .ecp(ecp),
    .hpm_event(hpm_event), .ext_irq(ext_irq), .timer_irq(timer_irq), .soft_irq(soft_irq),
    .eip(eip), .tip(tip), .sip(sip), .trap_vector(trap_vector), .mret_vector(mret_vector)
  );

  // Architectural state of the model: counters indexed by CSR number offset.
  longint unsigned m_cnt [32];
  bit              m_ie, m_pie;
  logic [31:0]     m_mie, m_mtvec, m_inh, m_scr, m_epc, m_cause, m_tval;
  int              n_checks = 0;
  int              n_errors = 0;

  logic [11:0] addr_tab [$] = '{
    12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC05, 12'hC06, 12'hC07, 12'hC1F, 12'hC20,
    12'hC80, 12'hC81, 12'hC82, 12'hC86, 12'hC87, 12'hC9F, 12'hCA0,
    12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB06, 12'hB07, 12'hB1F,
    12'hB80, 12'hB82, 12'hB84, 12'hB86,
    12'h300, 12'h301, 12'h302, 12'h304, 12'h305, 12'h306, 12'h320, 12'h323, 12'h33F,
    12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h345,
    12'hF10, 12'hF11, 12'hF14, 12'hF15, 12'h7C0, 12'h000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned cmask();
    return (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
  endfunction

  function automatic void model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ie = 0; m_pie = 0; m_mie = 0; m_inh = 0;
    m_scr = 0; m_epc = 0; m_cause = 0; m_tval = 0;
    m_mtvec = MTR & 32'hFFFF_FFFC;
  endfunction

  function automatic void model_read(input logic [11:0] a, output bit rd, output bit wr,
                                     output logic [31:0] v);
    int grp = int'(a[11:8]);
    int lo  = int'(a[7:0]);
    int idx = int'(a[4:0]);
    longint unsigned c;
    rd = 0; wr = 0; v = 0;
    if ((grp == 12 || grp == 11) && (lo < 'h20 || (lo >= 'h80 && lo < 'hA0))) begin
      rd = 1;
      wr = (grp == 11);
      if (idx == 0 || idx == 2 || (idx >= 3 && idx < 3 + HPM) || (idx == 1 && grp == 12)) begin
        c = m_cnt[(idx == 1) ? 0 : idx];
        v = (lo >= 'h80) ? c[63:32] : c[31:0];
      end
    end else if (a >= 12'hF11 && a <= 12'hF14) begin
      rd = 1;
    end else begin
      rd = 1;
      wr = 1;
      case (a)
        12'h300: v = (32'(m_pie) << 7) | (32'(m_ie) << 3);
        12'h301: v = 32'h4000_0100;
        12'h304: v = m_mie;
        12'h305: v = m_mtvec;
        12'h320: v = m_inh;
        12'h340: v = m_scr;
        12'h341: v = m_epc;
        12'h342: v = m_cause;
        12'h343: v = m_tval;
        12'h344: v = (32'(ext_irq) << 11) | (32'(timer_irq) << 7) | (32'(soft_irq) << 3);
        default: if (!(a >= 12'h323 && a <= 12'h33F)) begin rd = 0; wr = 0; end
      endcase
    end
  endfunction

  function automatic void model_step();
    bit              rd, wr, we, written, inc;
    logic [31:0]     dummy, d, inh_old;
    logic [11:0]     a;
    longint unsigned c;
    if (reset) begin
      model_reset();
      return;
    end
    a = bus.write_address;
    d = bus.write_data;
    inh_old = m_inh;
    model_read(a, rd, wr, dummy);
    we = bus.write_enable && wr;
    for (int n = 0; n < 3 + HPM; n++) begin
      if (n == 1) continue;
      if (n == 0)      inc = !inh_old[0];
      else if (n == 2) inc = retired && !inh_old[2];
      else             inc = hpm_event[n-3] && !inh_old[n];
      written = we && a[11:8] == 4'hB && int'(a[4:0]) == n;
      c = m_cnt[n];
      if (written) begin
        if (a[7]) c[63:32] = d;
        else      c[31:0]  = d;
        c = c & cmask();
      end else if (inc) begin
        c = (c + 1) & cmask();
      end
      m_cnt[n] = c;
    end
    if (traped) begin
      m_epc   = ecp & 32'hFFFF_FFFC;
      m_cause = {trap_interrupt, 27'b0, trap_code};
      m_tval  = trap_value;
      m_pie   = m_ie;
      m_ie    = 0;
    end else begin
      if (mret) begin
        m_ie = m_pie; m_pie = 1;
      end else if (we && a == 12'h300) begin
        m_ie = d[3]; m_pie = d[7];
      end
      if (we && a == 12'h341) m_epc = d & 32'hFFFF_FFFC;
      if (we && a == 12'h342) m_cause = d & 32'h8000_000F;
      if (we && a == 12'h343) m_tval = d;
    end
    if (we && a == 12'h304) m_mie = d & 32'h888;
`ifdef CSR_VECTORED_MTVEC_EN
    if (we && a == 12'h305) m_mtvec = (d & 32'hFFFF_FFFC) | ((d[1:0] == 2'b01) ? 32'h1 : 32'h0);
`else
    if (we && a == 12'h305) m_mtvec = d & 32'hFFFF_FFFC;
`endif
    if (we && a == 12'h320) m_inh = d & (32'h5 | (((32'd1 << HPM) - 1) << 3));
    if (we && a == 12'h340) m_scr = d;
  endfunction

  task automatic settle();
    bit          rd, wr;
    logic [31:0] v, tv;
    #1;
    model_read(bus.read_address, rd, wr, v);
    chk($sformatf("readable@%h", bus.read_address), 32'(bus.readable), 32'(rd));
    chk($sformatf("writeable@%h", bus.read_address), 32'(bus.writeable), 32'(wr));
    chk($sformatf("read_data@%h", bus.read_address), bus.read_data, v);
    chk("eip", 32'(eip), 32'(m_ie & m_mie[11] & ext_irq));
    chk("tip", 32'(tip), 32'(m_ie & m_mie[7] & timer_irq));
    chk("sip", 32'(sip), 32'(m_ie & m_mie[3] & soft_irq));
    tv = m_mtvec & 32'hFFFF_FFFC;
`ifdef CSR_VECTORED_MTVEC_EN
    if (m_mtvec[0] && m_cause[31]) tv = tv + {26'b0, m_cause[3:0], 2'b00};
`endif
    chk("trap_vector", trap_vector, tv);
    chk("mret_vector", mret_vector, m_epc);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle();
    bus.read_address = 12'h000; bus.write_enable = 0; bus.write_address = 12'h000;
    bus.write_data = 0; retired = 0; traped = 0; trap_interrupt = 0; trap_code = 0;
    trap_value = 0; mret = 0; ecp = 0; hpm_event = 0;
    ext_irq = 0; timer_irq = 0; soft_irq = 0;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    bus.write_enable = 1; bus.write_address = a; bus.write_data = d;
    tick();
    bus.write_enable = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.read_address = a;
    settle();
    chk(tag, bus.read_data, exp);
    advance();
  endtask

  function automatic logic [11:0] pick();
    return addr_tab[$urandom_range(0, addr_tab.size() - 1)];
  endfunction

  initial begin
    idle();
    reset = 1;
    model_reset();
    advance();
    reset = 0;
    rd_chk("rst_cycle", 12'hC00, 32'h0);
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mtvec", 12'h305, 32'h80);
    rd_chk("rst_mepc", 12'h341, 32'h0);

    for (int k = 0; k < 800; k++) begin
      reset              = ($urandom_range(0, 99) == 0);
      bus.write_enable   = ($urandom_range(0, 2) == 0);
      bus.write_address  = pick();
      bus.write_data     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2)
                                                        : $urandom;
      bus.read_address   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pick();
      retired            = 1'($urandom);
      hpm_event          = HPM'($urandom);
      traped             = ($urandom_range(0, 7) == 0);
      mret               = ($urandom_range(0, 7) == 0);
      trap_interrupt     = 1'($urandom);
      trap_code          = 4'($urandom);
      trap_value         = $urandom;
      ecp                = $urandom;
      ext_irq            = 1'($urandom);
      timer_irq          = 1'($urandom);
      soft_irq           = 1'($urandom);
      tick();
    end

    // Reset in the middle of activity.
    idle();
    reset = 0;
    wr_csr(12'h300, 32'h88);
    retired = 1;
    tick();
    retired = 0;
    reset = 1;
    tick();
    reset = 0;
    rd_chk("mid_rst_cycle", 12'hC00, 32'h0);
    rd_chk("mid_rst_instret", 12'hC02, 32'h0);
    rd_chk("mid_rst_mstatus", 12'h300, 32'h0);
    rd_chk("mid_rst_mtvec", 12'h305, 32'h80);

    // Low-half write then carry into the high half on its own.
    wr_csr(12'hB00, 32'hFFFF_FFFF);
    tick();
    tick();
    rd_chk("cycle_lo_wrap", 12'hC00, 32'h1);
    rd_chk("cycle_hi_wrap", 12'hC80, 32'h1);
    bus.read_address = 12'hC00;
    bus.write_enable = 1; bus.write_address = 12'hC00; bus.write_data = 32'h1234;
    settle();
    chk("ro_writeable", 32'(bus.writeable), 32'h0);
    advance();
    bus.write_enable = 0;
    rd_chk("ro_nochange", 12'hC00, 32'h4);

    // Timer interrupt enable path and cycle inhibit.
    wr_csr(12'h300, 32'h8);
    wr_csr(12'h304, 32'h888);
    timer_irq = 1;
    bus.read_address = 12'h344;
    settle();
    chk("tip_live", 32'(tip), 32'h1);
    chk("mip_timer", bus.read_data, 32'h80);
    advance();
    wr_csr(12'h320, 32'h1);
    rd_chk("inhibit_hold0", 12'hC00, 32'h9);
    rd_chk("inhibit_hold1", 12'hC00, 32'h9);
    timer_irq = 0;

    // Trap with simultaneous mret and mscratch write.
    traped = 1; ecp = 32'h1003; trap_code = 4'd2; trap_value = 32'hDEAD; mret = 1;
    wr_csr(12'h340, 32'h5);
    idle();
    rd_chk("trap_mepc", 12'h341, 32'h1000);
    rd_chk("trap_mcause", 12'h342, 32'h2);
    rd_chk("trap_mtval", 12'h343, 32'hDEAD);
    rd_chk("trap_mstatus", 12'h300, 32'h80);
    rd_chk("trap_mscratch", 12'h340, 32'h5);

    mret = 1;
    tick();
    mret = 0;
    rd_chk("mret_mstatus", 12'h300, 32'h88);
    chk("mret_vector_val", mret_vector, 32'h1000);

    // Vectored dispatch (or plain base when the feature is absent).
    wr_csr(12'h305, 32'h201);
`ifdef CSR_VECTORED_MTVEC_EN
    rd_chk("mtvec_mode", 12'h305, 32'h201);
`else
    rd_chk("mtvec_mode", 12'h305, 32'h200);
`endif
    traped = 1; trap_interrupt = 1; trap_code = 4'd7;
    tick();
    idle();
    settle();
`ifdef CSR_VECTORED_MTVEC_EN
    chk("vec_target", trap_vector, 32'h21C);
`else
    chk("vec_target", trap_vector, 32'h200);
`endif
    advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Parametrised successor of the machine-mode CSR unit: M-mode CSRs plus 64-bit cycle/instret and HPM_COUNT event counters with mcountinhibit.
- Adds full trap-state capture (mepc/mcause/mtval) and external/timer/software interrupt sampling.
- Read port sits beside decode; write port and trap/retire strobes come from writeback; trap_vector and mret_vector feed fetch.

Parameters:
- HPM_COUNT, 4, number of implemented mhpmcounter3..(3+HPM_COUNT-1); legal 0..29.
- COUNTER_WIDTH, 64, implemented bits of every counter; legal 32..64. Upper bits read 0. Counters wrap at 2^COUNTER_WIDTH.
- MTVEC_RESET, 32'h0, reset value of mtvec; bits [1:0] are forced to 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- read_address  in  12  decode read CSR address.
- read_data  out  32  read value; combinational.
- readable  out  1  address implemented.
- writeable  out  1  address writable; 0 means illegal write.
- write_enable  in  1  commit CSR write.
- write_address  in  12  write CSR address.
- write_data  in  32  full new value; RMW already resolved upstream.
- retired  in  1  one instruction retired this cycle.
- traped  in  1  trap taken this cycle.
- trap_interrupt  in  1  trap is an interrupt.
- trap_code  in  4  exception/interrupt code.
- trap_value  in  32  mtval value.
- mret  in  1  mret committed.
- ecp  in  32  PC of the trapping instruction.
- hpm_event  in  HPM_COUNT  per-counter increment strobes.
- ext_irq, timer_irq, soft_irq  in  1 each  level interrupt lines.
- eip, tip, sip  out  1 each  interrupt enabled and pending (ie & mie bit & mip bit).
- trap_vector  out  32  trap target PC.
- mret_vector  out  32  current mepc.

Behaviour:
- Reset: ie=0, pie=0, mie=0, mtvec=MTVEC_RESET, mscratch/mepc/mcause/mtval=0, all counters=0, mcountinhibit=0. All outputs follow from these values.
- Reads are combinational. A write is visible on read_data the cycle after the write_enable edge.
- Address map, read-only, readable=1 writeable=0:
  - C00/C01 cycle, C02 instret, C03+i hpmcounter; C80/C81/C82/C83+i are the high halves.
  - Other C0x-C1x and C8x-C9x addresses read 0.
  - F11-F14 read 0.
- Address map, readable=1 writeable=1:
  - B00 mcycle, B02 minstret, B03+i mhpmcounter, and B80/B82/B83+i high halves. Unimplemented B0x-B1x and B8x-B9x read 0 and writes are ignored.
  - 300 mstatus: MIE at bit 3, MPIE at bit 7, all other bits 0.
  - 301 misa: reads 32'h40000100; writes ignored.
  - 304 mie: bits 11/7/3 writable, others 0.
  - 305 mtvec.
  - 320 mcountinhibit: bits 0, 2, and 3..3+HPM_COUNT-1 writable.
  - 323-33F mhpmevent: read 0, writes ignored.
  - 340 mscratch.
  - 341 mepc: bits [1:0] always 0.
  - 342 mcause: bit 31 and bits [3:0] held, others 0.
  - 343 mtval.
  - 344 mip: bits 11/7/3 are the live ext/timer/soft irq lines; writes ignored.
- Any other address: readable=0, writeable=0, read_data=0. A write_enable to such an address changes nothing.
- Counter increments:
  - cycle +1 every cycle unless inhibit[0].
  - instret +1 on retired unless inhibit[2].
  - hpm[i] +1 on hpm_event[i] unless inhibit[3+i].
- Writing a low or high half replaces only that half; there is no carry into the other half. A CSR write to a counter in the same cycle as its increment: the written value wins and the increment is dropped.
- Trap (traped=1):
  - mepc <= ecp & ~3
  - mcause <= {trap_interrupt, 27'b0, trap_code}
  - mtval <= trap_value
  - pie <= ie; ie <= 0.
- mret:
  - ie <= pie; pie <= 1.
  - If traped and mret are both asserted, only the trap takes effect.
- traped and write_enable in the same cycle: the trap update wins for mstatus, mepc, mcause and mtval; writes to any other CSR still apply.
- trap_vector = {mtvec[31:2], 2'b00} unless vectored mode applies (see Optional Feature).

Optional Feature:
- Macro CSR_VECTORED_MTVEC_EN.
- Defined:
  - mtvec[1:0] is writable, but only value 0 or 1 is retained; writing 2 or 3 stores 0.
  - When mode=1 and mcause[31]=1: trap_vector = base + 4*mcause[3:0].
  - Otherwise trap_vector = base.
- Undefined: mtvec[1:0] reads 0, writes to it are ignored, and trap_vector is always base.

Test Plan:
- Reset asserted mid-run with counters at nonzero values → next cycle cycle=0, instret=0, mstatus=0, mtvec reads MTVEC_RESET.
- Write B00 with 32'hFFFFFFFF, then run 2 cycles → C00=1, C80=1. Write C00 → writeable=0 and no change.
- ie=1, mie=32'h888, assert timer_irq → tip=1, mip reads 32'h80. Set inhibit bit 0 → cycle holds its value.
- traped with ecp=32'h1003, code=2, trap_value=32'hDEAD and mret in the same cycle, plus a write 340=5 → mepc=32'h1000, mcause=2, mtval=32'hDEAD, ie=0, pie=old ie, mscratch=5.
- mret after the trap → ie restored, mstatus MPIE=1, mret_vector=32'h1000.
- With CSR_VECTORED_MTVEC_EN: mtvec=32'h201, interrupt trap with code 7 → trap_vector=32'h21C. Without the macro the same stimulus gives mtvec reading 32'h200 and trap_vector=32'h200.
